inst_queue: RTL and testbench
=============================

Name: inst_queue

Overview:
- Parametrised instruction queue between fetch and decode; next generation of the dual-issue fetch buffer.
- Circular FIFO of IN_W-wide fetch groups in, OUT_W-wide issue window out.
- Per-entry exception tagging replaces the single global exception input.
- Adds a configurable backpressure threshold, consume clamping and overflow detection.

Parameters:
- DEPTH, 8, entry count; power of 2, >= 2*IN_W.
- IN_W, 2, fetch lanes accepted per cycle.
- OUT_W, 2, issue lanes presented per cycle; OUT_W <= DEPTH.
- RESERVE, 2*IN_W, free slots required for in_ready, covering the in-flight fetch.
- NOP_INST, 32'h03400000, instruction word substituted on excepting entries.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high
- flush  in  1  discard all contents
- in_size  in  $clog2(IN_W+1)  valid lanes this cycle; lanes contiguous from lane 0
- in_ready  out  1  free >= RESERVE
- in_pc  in  IN_W x 32  per-lane PC
- in_inst  in  IN_W x 32  per-lane instruction
- in_pred_taken  in  IN_W  per-lane predicted taken
- in_pred_target  in  IN_W x 32  per-lane predicted target
- in_excp  in  IN_W  per-lane fetch exception
- in_ecode  in  IN_W x exception_t  per-lane exception type
- out_valid  out  OUT_W  thermometer code; bit k = count > k
- out_pc, out_inst, out_pred_taken, out_pred_target, out_excp, out_ecode  out  OUT_W x field  entry head+k
- consume  in  $clog2(OUT_W+1)  entries retired this cycle
- count  out  $clog2(DEPTH+1)  current occupancy
- overflow_err  out  1  sticky overflow flag

Behaviour:
- State: storage arrays, head and tail pointers ($clog2(DEPTH) bits, natural wrap), count.
- Outputs are combinational from head and count; zero-latency view.
- A written entry is visible on out_* the cycle after the write. There is no same-cycle bypass.
- Reset or flush: head=0, tail=0, count=0, out_valid=0, in_ready=1.
  - Reset also clears overflow_err; flush does not.
  - Storage arrays are not cleared.
- Reset and flush both override any same-cycle in_size and consume.
- eff_consume = min(consume, count); excess is ignored.
- Accept condition: in_size <= DEPTH - count, using count at cycle start; same-cycle consume does not free space.
  - Accepted: lane i is written at tail+i for i < in_size; tail += in_size.
  - Rejected: the whole group is dropped, no partial write, and overflow_err is set.
- Each cycle: head += eff_consume; count += accepted_size - eff_consume. All arithmetic is widened to count width.
- in_ready = (DEPTH - count) >= RESERVE. It is advisory only; the accept check governs.
- out_inst[k] = NOP_INST when out_excp[k]=1, otherwise the stored instruction.
- Fields of lanes with out_valid[k]=0 are don't-care.
- Full queue (count=DEPTH) with simultaneous consume 2 and in_size 2: input is rejected.
- Empty queue: consume is ignored, count stays 0.

Optional Feature:
- Macro: INST_QUEUE_STAT_EN.
- Defined:
  - Adds outputs stat_empty_cyc, stat_stall_cyc and stat_issue_cnt, each 32 bits.
  - stat_empty_cyc counts cycles with count=0.
  - stat_stall_cyc counts cycles with in_ready=0.
  - stat_issue_cnt accumulates eff_consume.
  - All three wrap at 2^32, clear on reset, and are unaffected by flush.
- Undefined: ports and logic are absent; core behaviour is identical.

Decomposition:
- Shared package (existing definitions package):
  - exception_t.
  - NOP_INST constant 32'h03400000.
  - Struct iq_entry_t {pc, inst, pred_taken, pred_target, excp, ecode}.
  - Storage is an array of iq_entry_t.
- Sub-module iq_ptr_ctrl: head/tail/count, clamp, accept and overflow logic.
- inst_queue keeps the storage array and the read-mux.

Test Plan:
- Reset, then in_size=2 with pcs 0x1c000000/0x1c000004, consume=0:
  - Next cycle count=2, out_valid=2'b11, out_pc[0]=0x1c000000, out_pc[1]=0x1c000004.
- Fill 2 per cycle, no consume (DEPTH=8):
  - in_ready drops when count=5.
  - At count=8, in_size=2 is rejected: count stays 8 and overflow_err=1.
- Wrap-around: stream 20 sequential pcs in pairs with consume=2 each cycle.
  - Out order is strictly increasing and no entry is lost.
  - count stays at 2 after the first cycle.
- count=1 with consume=2: head advances by 1 and count=0; no underflow.
- Lane 1 in_excp=1 with ecode ADEF: out_inst[1]=0x03400000, out_excp[1]=1, out_ecode matches.
- flush with count=6 and in_size=2 in the same cycle: next cycle count=0, out_valid=0, overflow_err unchanged.

Source files
------------

// File: rtl/inst_queue_pkg.sv
// Shared definitions for the fetch-to-decode instruction queue: exception codes,
// the NOP substituted on excepting entries, and the stored entry layout.
package inst_queue_pkg;

    typedef enum logic [5:0] {
        EXC_NONE = 6'h00,
        EXC_PIF  = 6'h03,
        EXC_PPI  = 6'h07,
        EXC_ADEF = 6'h08,
        EXC_TLBR = 6'h3f
    } exception_t;

    localparam logic [31:0] NOP_INST = 32'h03400000;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic        pred_taken;
        logic [31:0] pred_target;
        logic        excp;
        exception_t  ecode;
    } iq_entry_t;

endpackage

// File: rtl/iq_ptr_ctrl.sv
// Head/tail/occupancy bookkeeping for inst_queue: consume clamping, whole-group
// accept check against start-of-cycle occupancy, and the sticky overflow flag.
module iq_ptr_ctrl #(
    parameter  int DEPTH   = 8,
    parameter  int IN_W    = 2,
    parameter  int OUT_W   = 2,
    parameter  int RESERVE = 2 * IN_W,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int CNT_W   = $clog2(DEPTH + 1),
    localparam int ISZ_W   = $clog2(IN_W + 1),
    localparam int CSM_W   = $clog2(OUT_W + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_flush,
    input  logic [ISZ_W-1:0] i_in_size,
    input  logic [CSM_W-1:0] i_consume,
    output logic [PTR_W-1:0] o_head,
    output logic [PTR_W-1:0] o_tail,
    output logic [CNT_W-1:0] o_count,
    output logic             o_wr_en,
    output logic [CNT_W-1:0] o_eff_consume,
    output logic             o_in_ready,
    output logic             o_overflow_err
);

    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow_err;

    logic [CNT_W-1:0] w_free;
    logic [CNT_W-1:0] w_in_size;
    logic [CNT_W-1:0] w_consume;
    logic [CNT_W-1:0] w_eff_consume;
    logic [CNT_W-1:0] w_acc_size;
    logic             w_accept;
    logic             w_idle;

    assign w_idle        = reset | i_flush;
    assign w_free        = CNT_W'(DEPTH) - r_count;
    assign w_in_size     = CNT_W'(i_in_size);
    assign w_consume     = CNT_W'(i_consume);
    // Space check uses start-of-cycle occupancy; a same-cycle retire frees nothing.
    assign w_accept      = (w_in_size <= w_free);
    assign w_eff_consume = (w_consume > r_count) ? r_count : w_consume;
    assign w_acc_size    = w_accept ? w_in_size : '0;

    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every register samples start-of-cycle values.
        if (reset) begin
            r_head         <= '0;
            r_tail         <= '0;
            r_count        <= '0;
            r_overflow_err <= 1'b0;
        end else if (i_flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_head  <= r_head + PTR_W'(w_eff_consume);
            r_tail  <= r_tail + PTR_W'(w_acc_size);
            r_count <= r_count + w_acc_size - w_eff_consume;
            if (!w_accept) begin
                r_overflow_err <= 1'b1;
            end
        end
    end

    assign o_head         = r_head;
    assign o_tail         = r_tail;
    assign o_count        = r_count;
    assign o_wr_en        = w_accept & ~w_idle;
    assign o_eff_consume  = w_idle ? '0 : w_eff_consume;
    assign o_in_ready     = (w_free >= CNT_W'(RESERVE));
    assign o_overflow_err = r_overflow_err;

endmodule

// File: rtl/inst_queue.sv
// Circular instruction queue between fetch and decode with per-entry exception tags.
// Optional statistics counters are built when INST_QUEUE_STAT_EN is defined.
module inst_queue
    import inst_queue_pkg::*;
#(
    parameter  int          DEPTH    = 8,
    parameter  int          IN_W     = 2,
    parameter  int          OUT_W    = 2,
    parameter  int          RESERVE  = 2 * IN_W,
    parameter  logic [31:0] NOP_INST = inst_queue_pkg::NOP_INST,
    localparam int          PTR_W    = $clog2(DEPTH),
    localparam int          CNT_W    = $clog2(DEPTH + 1),
    localparam int          ISZ_W    = $clog2(IN_W + 1),
    localparam int          CSM_W    = $clog2(OUT_W + 1)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        flush,
    input  logic [ISZ_W-1:0]            in_size,
    output logic                        in_ready,
    input  logic [IN_W-1:0][31:0]       in_pc,
    input  logic [IN_W-1:0][31:0]       in_inst,
    input  logic [IN_W-1:0]             in_pred_taken,
    input  logic [IN_W-1:0][31:0]       in_pred_target,
    input  logic [IN_W-1:0]             in_excp,
    input  exception_t [IN_W-1:0]       in_ecode,
    output logic [OUT_W-1:0]            out_valid,
    output logic [OUT_W-1:0][31:0]      out_pc,
    output logic [OUT_W-1:0][31:0]      out_inst,
    output logic [OUT_W-1:0]            out_pred_taken,
    output logic [OUT_W-1:0][31:0]      out_pred_target,
    output logic [OUT_W-1:0]            out_excp,
    output exception_t [OUT_W-1:0]      out_ecode,
    input  logic [CSM_W-1:0]            consume,
    output logic [CNT_W-1:0]            count,
    output logic                        overflow_err
`ifdef INST_QUEUE_STAT_EN
    ,
    output logic [31:0]                 stat_empty_cyc,
    output logic [31:0]                 stat_stall_cyc,
    output logic [31:0]                 stat_issue_cnt
`endif
);

    logic [PTR_W-1:0] w_head;
    logic [PTR_W-1:0] w_tail;
    logic [CNT_W-1:0] w_count;
    logic             w_wr_en;
    logic [CNT_W-1:0] w_eff_consume;
    logic             w_in_ready;

    iq_entry_t r_mem      [DEPTH];
    iq_entry_t w_wr_entry [IN_W];
    iq_entry_t w_rd_entry [OUT_W];

    iq_ptr_ctrl #(
        .DEPTH   (DEPTH),
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .RESERVE (RESERVE)
    ) u_ptr_ctrl (
        .clk            (clk),
        .reset          (reset),
        .i_flush        (flush),
        .i_in_size      (in_size),
        .i_consume      (consume),
        .o_head         (w_head),
        .o_tail         (w_tail),
        .o_count        (w_count),
        .o_wr_en        (w_wr_en),
        .o_eff_consume  (w_eff_consume),
        .o_in_ready     (w_in_ready),
        .o_overflow_err (overflow_err)
    );

    always_comb begin
        for (int i = 0; i < IN_W; i++) begin
            // NOTE: defaults first so no latch is inferred on any field.
            w_wr_entry[i]             = '0;
            w_wr_entry[i].pc          = in_pc[i];
            w_wr_entry[i].inst        = in_inst[i];
            w_wr_entry[i].pred_taken  = in_pred_taken[i];
            w_wr_entry[i].pred_target = in_pred_target[i];
            w_wr_entry[i].excp        = in_excp[i];
            w_wr_entry[i].ecode       = in_ecode[i];
        end
    end

    // NOTE: storage is deliberately not reset; out_valid masks stale entries.
    always_ff @(posedge clk) begin
        for (int i = 0; i < IN_W; i++) begin
            if (w_wr_en && (i < int'(in_size))) begin
                r_mem[w_tail + PTR_W'(i)] <= w_wr_entry[i];
            end
        end
    end

    // Zero-latency issue window: entry head+k on lane k, wrapping naturally.
    always_comb begin
        for (int k = 0; k < OUT_W; k++) begin
            w_rd_entry[k]      = r_mem[w_head + PTR_W'(k)];
            out_valid[k]       = (w_count > CNT_W'(k));
            out_pc[k]          = w_rd_entry[k].pc;
            out_inst[k]        = w_rd_entry[k].excp ? NOP_INST : w_rd_entry[k].inst;
            out_pred_taken[k]  = w_rd_entry[k].pred_taken;
            out_pred_target[k] = w_rd_entry[k].pred_target;
            out_excp[k]        = w_rd_entry[k].excp;
            out_ecode[k]       = w_rd_entry[k].ecode;
        end
    end

    assign count    = w_count;
    assign in_ready = w_in_ready;

`ifdef INST_QUEUE_STAT_EN
    logic [31:0] r_stat_empty_cyc;
    logic [31:0] r_stat_stall_cyc;
    logic [31:0] r_stat_issue_cnt;

    // Flush leaves the statistics alone; only reset clears them.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_stat_empty_cyc <= '0;
            r_stat_stall_cyc <= '0;
            r_stat_issue_cnt <= '0;
        end else begin
            if (w_count == '0) begin
                r_stat_empty_cyc <= r_stat_empty_cyc + 32'd1;
            end
            if (!w_in_ready) begin
                r_stat_stall_cyc <= r_stat_stall_cyc + 32'd1;
            end
            r_stat_issue_cnt <= r_stat_issue_cnt + 32'(w_eff_consume);
        end
    end

    assign stat_empty_cyc = r_stat_empty_cyc;
    assign stat_stall_cyc = r_stat_stall_cyc;
    assign stat_issue_cnt = r_stat_issue_cnt;
`endif

endmodule

// File: tb/tb_inst_queue.sv
// Self-checking bench for inst_queue: directed boundary steps, then random traffic,
// all compared against a queue-based reference model.
module tb_inst_queue;
    import inst_queue_pkg::*;

    localparam int DEPTH   = 8;
    localparam int IN_W    = 2;
    localparam int OUT_W   = 2;
    localparam int RESERVE = 2 * IN_W;
    localparam logic [31:0] NOP = 32'h03400000;

    logic                   clk;
    logic                   reset;
    logic                   flush;
    logic [1:0]             in_size;
    logic                   in_ready;
    logic [IN_W-1:0][31:0]  in_pc;
    logic [IN_W-1:0][31:0]  in_inst;
    logic [IN_W-1:0]        in_pred_taken;
    logic [IN_W-1:0][31:0]  in_pred_target;
    logic [IN_W-1:0]        in_excp;
    exception_t [IN_W-1:0]  in_ecode;
    logic [OUT_W-1:0]       out_valid;
    logic [OUT_W-1:0][31:0] out_pc;
    logic [OUT_W-1:0][31:0] out_inst;
    logic [OUT_W-1:0]       out_pred_taken;
    logic [OUT_W-1:0][31:0] out_pred_target;
    logic [OUT_W-1:0]       out_excp;
    exception_t [OUT_W-1:0] out_ecode;
    logic [1:0]             consume;
    logic [3:0]             count;
    logic                   overflow_err;

    inst_queue #(
        .DEPTH   (DEPTH),
        .IN_W    (IN_W),
        .OUT_W   (OUT_W),
        .RESERVE (RESERVE)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .flush           (flush),
        .in_size         (in_size),
        .in_ready        (in_ready),
        .in_pc           (in_pc),
        .in_inst         (in_inst),
        .in_pred_taken   (in_pred_taken),
        .in_pred_target  (in_pred_target),
        .in_excp         (in_excp),
        .in_ecode        (in_ecode),
        .out_valid       (out_valid),
        .out_pc          (out_pc),
        .out_inst        (out_inst),
        .out_pred_taken  (out_pred_taken),
        .out_pred_target (out_pred_target),
        .out_excp        (out_excp),
        .out_ecode       (out_ecode),
        .consume         (consume),
        .count           (count),
        .overflow_err    (overflow_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int        n_pass  = 0;
    int        n_fail  = 0;
    int        n_total = 0;
    iq_entry_t model_q[$];
    bit        model_ovf;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present a fetch group of n lanes with sequential pcs; excp marks lanes as ADEF.
    task automatic drive_group(input int n, input logic [31:0] pc0, input logic [IN_W-1:0] excp);
        in_size = 2'(n);
        for (int i = 0; i < IN_W; i++) begin
            in_pc[i]          = pc0 + 32'(4 * i);
            in_inst[i]        = $urandom;
            in_pred_taken[i]  = 1'($urandom_range(0, 1));
            in_pred_target[i] = $urandom;
            in_excp[i]        = excp[i];
            in_ecode[i]       = excp[i] ? EXC_ADEF : EXC_NONE;
        end
    endtask

    task automatic compare_all();
        int sz;
        iq_entry_t e;
        sz = model_q.size();
        check("count", 64'(count), 64'(sz));
        check("in_ready", 64'(in_ready), 64'((DEPTH - sz) >= RESERVE));
        check("overflow_err", 64'(overflow_err), 64'(model_ovf));
        for (int k = 0; k < OUT_W; k++) begin
            check($sformatf("out_valid[%0d]", k), 64'(out_valid[k]), 64'(sz > k));
            if (k < sz) begin
                e = model_q[k];
                check($sformatf("out_pc[%0d]", k), 64'(out_pc[k]), 64'(e.pc));
                check($sformatf("out_inst[%0d]", k), 64'(out_inst[k]), 64'(e.excp ? NOP : e.inst));
                check($sformatf("out_excp[%0d]", k), 64'(out_excp[k]), 64'(e.excp));
                check($sformatf("out_ecode[%0d]", k), 64'(out_ecode[k]), 64'(e.ecode));
                check($sformatf("out_taken[%0d]", k), 64'(out_pred_taken[k]), 64'(e.pred_taken));
                check($sformatf("out_target[%0d]", k), 64'(out_pred_target[k]), 64'(e.pred_target));
            end
        end
    endtask

    // Update the reference model from the current inputs, clock once, then compare.
    task automatic cycle();
        int sz;
        int eff;
        bit acc;
        iq_entry_t e;
        if (reset) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else if (flush) begin
            model_q.delete();
        end else begin
            sz  = int'(in_size);
            acc = (sz <= DEPTH - model_q.size());
            eff = (int'(consume) > model_q.size()) ? model_q.size() : int'(consume);
            repeat (eff) void'(model_q.pop_front());
            if (acc) begin
                for (int i = 0; i < sz; i++) begin
                    e.pc          = in_pc[i];
                    e.inst        = in_inst[i];
                    e.pred_taken  = in_pred_taken[i];
                    e.pred_target = in_pred_target[i];
                    e.excp        = in_excp[i];
                    e.ecode       = in_ecode[i];
                    model_q.push_back(e);
                end
            end else begin
                model_ovf = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        compare_all();
    endtask

    initial begin
        logic [31:0] prev_pc;
        logic [31:0] lane0_inst;
        reset   = 1'b1;
        flush   = 1'b0;
        consume = 2'd0;
        drive_group(0, 32'h0, 2'b00);
        model_ovf = 1'b0;
        #2;
        cycle();
        check("reset_count", 64'(count), 64'd0);
        check("reset_valid", 64'(out_valid), 64'd0);
        check("reset_ready", 64'(in_ready), 64'd1);

        // First pair becomes visible the cycle after the write.
        reset = 1'b0;
        drive_group(2, 32'h1c000000, 2'b00);
        cycle();
        check("first_count", 64'(count), 64'd2);
        check("first_valid", 64'(out_valid), 64'b11);
        check("first_pc0", 64'(out_pc[0]), 64'h1c000000);
        check("first_pc1", 64'(out_pc[1]), 64'h1c000004);

        drive_group(2, 32'h1c000008, 2'b00);
        cycle();
        check("ready_at4", 64'(in_ready), 64'd1);
        drive_group(1, 32'h1c000010, 2'b00);
        cycle();
        check("ready_at5", 64'(in_ready), 64'd0);
        drive_group(1, 32'h1c000014, 2'b00);
        cycle();
        drive_group(2, 32'h1c000018, 2'b00);
        cycle();
        check("full_count", 64'(count), 64'd8);
        check("full_no_ovf", 64'(overflow_err), 64'd0);

        drive_group(2, 32'h1c000020, 2'b00);
        cycle();
        check("reject_count", 64'(count), 64'd8);
        check("reject_ovf", 64'(overflow_err), 64'd1);

        // Full queue: consume does not make room for a same-cycle group.
        consume = 2'd2;
        drive_group(2, 32'h1c000028, 2'b00);
        cycle();
        check("full_cons_count", 64'(count), 64'd6);
        check("full_cons_pc0", 64'(out_pc[0]), 64'h1c000008);

        consume = 2'd0;
        flush   = 1'b1;
        drive_group(2, 32'h1c000030, 2'b00);
        cycle();
        check("flush_count", 64'(count), 64'd0);
        check("flush_valid", 64'(out_valid), 64'd0);
        check("flush_ovf", 64'(overflow_err), 64'd1);
        flush = 1'b0;

        // Stream 20 pcs in pairs through the wrap point.
        consume = 2'd2;
        prev_pc = 32'h0;
        for (int j = 0; j < 10; j++) begin
            drive_group(2, 32'h1000 + 32'(8 * j), 2'b00);
            cycle();
            check("wrap_count", 64'(count), 64'd2);
            check("wrap_pc0", 64'(out_pc[0]), 64'(32'h1000 + 32'(8 * j)));
            check("wrap_order", 64'(out_pc[0] > prev_pc), 64'd1);
            prev_pc = out_pc[1];
        end
        drive_group(0, 32'h0, 2'b00);
        cycle();
        check("drain_count", 64'(count), 64'd0);

        // count=1 with consume=2 clamps to a single retire.
        consume = 2'd0;
        drive_group(1, 32'h2000, 2'b00);
        cycle();
        consume = 2'd2;
        drive_group(0, 32'h0, 2'b00);
        cycle();
        check("clamp_count", 64'(count), 64'd0);
        consume = 2'd2;
        cycle();
        check("empty_cons_count", 64'(count), 64'd0);
        consume = 2'd0;
        drive_group(1, 32'h3000, 2'b00);
        cycle();
        check("clamp_next_pc", 64'(out_pc[0]), 64'h3000);

        // Exception on lane 1 substitutes the NOP.
        consume = 2'd1;
        drive_group(2, 32'h4000, 2'b10);
        lane0_inst = in_inst[0];
        cycle();
        check("excp_inst1", 64'(out_inst[1]), 64'(NOP));
        check("excp_flag1", 64'(out_excp[1]), 64'd1);
        check("excp_ecode1", 64'(out_ecode[1]), 64'(EXC_ADEF));
        check("excp_flag0", 64'(out_excp[0]), 64'd0);
        check("excp_inst0", 64'(out_inst[0]), 64'(lane0_inst));

        reset   = 1'b1;
        consume = 2'd0;
        cycle();
        check("rst_ovf_clear", 64'(overflow_err), 64'd0);
        reset = 1'b0;

        for (int n = 0; n < 400; n++) begin
            flush   = ($urandom_range(0, 31) == 0);
            consume = 2'($urandom_range(0, 2));
            drive_group($urandom_range(0, 2), $urandom & 32'hffff_fffc,
                        IN_W'($urandom_range(0, 3) & $urandom_range(0, 3)));
            cycle();
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
